// File: rtl/float_max_scan.sv
// float_max_scan: streams a configured number of IEEE-754 samples, tracking the running maximum and its index.
module float_max_scan #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [IDX_W-1:0]  cfg_length,
  input  logic [IDX_W-1:0]  cfg_delay,
  input  logic [DATA_W-1:0] in0,
  input  logic              in0_valid,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  max_idx,
  output logic              nan_seen,
  output logic              done
);
  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, SCAN = 2'd2, DONE = 2'd3;
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic [1:0]       state;
  logic [IDX_W-1:0] len, dly, cnt;
  logic             have_max, is_nan, ge, repl, last;
  // ge(max_val, in0) in sign-magnitude order, so +0 ranks above -0
  always_comb begin
    is_nan = (&in0[DATA_W-2 -: EXP_W]) & (|in0[MAN_W-1:0]);
    ge = (max_val[DATA_W-1] & in0[DATA_W-1]) ? (max_val[DATA_W-2:0] <= in0[DATA_W-2:0]) :
         (max_val[DATA_W-1] == in0[DATA_W-1]) ? (max_val[DATA_W-2:0] >= in0[DATA_W-2:0]) :
         ~max_val[DATA_W-1];
    repl = ~is_nan & (~have_max | ~ge);
    last = cnt == len - IDX_W'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      dly      <= '0;
      cnt      <= '0;
      have_max <= 1'b0;
      max_val  <= '0;
      max_idx  <= '0;
      nan_seen <= 1'b0;
      done     <= 1'b0;
    end else if (run) begin
      len      <= cfg_length;
      dly      <= cfg_delay;
      cnt      <= '0;
      have_max <= 1'b0;
      nan_seen <= 1'b0;
      done     <= cfg_delay == '0 && cfg_length == '0;
      state    <= cfg_delay != '0 ? WAIT : cfg_length != '0 ? SCAN : DONE;
      if (cfg_delay == '0 && cfg_length == '0) begin
        max_val <= QNAN;
        max_idx <= '1;
      end
    end else if (running) begin
      if (state == WAIT) begin
        dly <= dly - IDX_W'(1);
        if (dly == IDX_W'(1)) begin
          state <= len == '0 ? DONE : SCAN;
          done  <= len == '0;
          if (len == '0) begin
            max_val <= QNAN;
            max_idx <= '1;
          end
        end
      end else if (state == SCAN && in0_valid) begin
        cnt <= cnt + IDX_W'(1);
        if (is_nan) nan_seen <= 1'b1;
        if (repl) begin
          max_val  <= in0;
          max_idx  <= cnt;
          have_max <= 1'b1;
        end
        if (last) begin
          state <= DONE;
          done  <= 1'b1;
          // nothing comparable was ever accepted: report the canonical quiet NaN
          if (~have_max & is_nan) begin
            max_val <= QNAN;
            max_idx <= '1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_float_max_scan.sv
// tb_float_max_scan: directed scans checked against a scoreboard of expected results.
module tb_float_max_scan;
  logic        clk = 0, rst = 1, running = 1, run = 0, in0_valid = 0, nan_seen, done;
  logic [15:0] cfg_length = 0, cfg_delay = 0, max_idx;
  logic [31:0] in0 = 0, max_val;
  int checks = 0, errors = 0;
  typedef struct { logic [31:0] v; logic [15:0] i; logic n; } exp_t;
  exp_t sb[$];

  float_max_scan dut (.clk(clk), .rst(rst), .running(running), .run(run), .cfg_length(cfg_length),
    .cfg_delay(cfg_delay), .in0(in0), .in0_valid(in0_valid), .max_val(max_val), .max_idx(max_idx),
    .nan_seen(nan_seen), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] l, input logic [15:0] d, input logic v);
    @(negedge clk);
    run = 1; cfg_length = l; cfg_delay = d; in0_valid = v;
  endtask

  task automatic feed(input logic [31:0] x);
    @(negedge clk);
    run = 0; in0 = x; in0_valid = 1;
  endtask

  task automatic idle();
    @(negedge clk);
    run = 0; in0_valid = 0;
  endtask

  task automatic expect_result(input logic [31:0] v, input logic [15:0] i, input logic n);
    exp_t e;
    e.v = v; e.i = i; e.n = n;
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_val"}, max_val, e.v);
      chk({tag, "_idx"}, {16'd0, max_idx}, {16'd0, e.i});
      chk({tag, "_nan"}, {31'd0, nan_seen}, {31'd0, e.n});
    end
  endtask

  initial begin
    #12;
    chk("rst_val", max_val, 32'h0);
    chk("rst_idx", {16'd0, max_idx}, 32'h0);
    chk("rst_nan", {31'd0, nan_seen}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    @(negedge clk) rst = 0;

    start(4, 0, 0); expect_result(32'h40600000, 1, 0);
    feed(32'h3F800000); feed(32'h40600000); feed(32'hC0000000); feed(32'h40000000);
    chk("basic_done_early", {31'd0, done}, 32'd0);
    idle(); check_result("basic");

    start(3, 0, 0); expect_result(32'h00000000, 1, 0);
    feed(32'h80000000); feed(32'h00000000); feed(32'h00000000);
    idle(); check_result("zeros");

    start(3, 0, 0); expect_result(32'hBF800000, 1, 0);
    feed(32'hC0A00000); feed(32'hBF800000); feed(32'hBF800000);
    idle(); check_result("negs");

    start(3, 0, 0); expect_result(32'h40000000, 0, 1);
    feed(32'h40000000); feed(32'h7FC00001); feed(32'h3F800000);
    idle(); check_result("nan_mix");

    start(2, 0, 0); expect_result(32'h7FC00000, 16'hFFFF, 1);
    feed(32'h7FC00001); feed(32'hFFC00000);
    idle(); check_result("all_nan");

    // large samples offered during WAIT and during the stall must never be taken
    start(2, 3, 1); in0 = 32'h50000000; expect_result(32'h40000000, 0, 0);
    feed(32'h50000000); feed(32'h50000000); feed(32'h50000000);
    feed(32'h40000000);
    @(negedge clk) begin running = 0; in0 = 32'h50000000; end
    @(negedge clk);
    chk("stall_done_early", {31'd0, done}, 32'd0);
    @(negedge clk) begin running = 1; in0 = 32'h3F800000; end
    chk("stall_done_before_last", {31'd0, done}, 32'd0);
    idle(); check_result("delay_stall");

    start(0, 0, 0); expect_result(32'h7FC00000, 16'hFFFF, 0);
    idle();
    chk("zero_len_done_next", {31'd0, done}, 32'd1);
    check_result("zero_len");

    start(3, 0, 0);
    feed(32'h7F7FFFFF); feed(32'h3F800000);
    start(1, 0, 0); expect_result(32'h7F800000, 0, 0);
    feed(32'h7F800000);
    idle(); check_result("restart");

    start(4, 0, 0);
    feed(32'h7FC00001); feed(32'h40000000);
    @(posedge clk); #3 rst = 1;
    #1;
    chk("arst_val", max_val, 32'h0);
    chk("arst_idx", {16'd0, max_idx}, 32'h0);
    chk("arst_nan", {31'd0, nan_seen}, 32'h0);
    chk("arst_done", {31'd0, done}, 32'h0);
    @(negedge clk) begin rst = 0; in0 = 32'h41000000; in0_valid = 1; end
    feed(32'h41000000); feed(32'h41000000);
    idle();
    chk("post_rst_val", max_val, 32'h0);
    chk("post_rst_done", {31'd0, done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
